// File: rtl/spike_rx_buf.sv
// AER receive endpoint: packet FIFO, core/axon decode, pending/active spike vectors
// with two independent one-cycle-latency read ports.
module spike_rx_buf #(
  parameter int NUM_AXONS          = 4,
  parameter int AXON_CNT_BIT_WIDTH = 2,
  parameter int AER_BIT_WIDTH      = 32,
  parameter int CORE_ID_BIT_WIDTH  = 8,
  parameter logic [CORE_ID_BIT_WIDTH-1:0] CORE_ID = 8'h01,
  parameter int FIFO_DEPTH         = 4,
  parameter int FIFO_PTR_BIT_WIDTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [AER_BIT_WIDTH-1:0]      pkt_i,
  input  logic                          pktValid_i,
  output logic                          pktReady_o,
  input  logic [AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_i,
  input  logic                          rdEn_RclInSpike_i,
  output logic                          Rcl_InSpike_o,
  input  logic [AXON_CNT_BIT_WIDTH-1:0] LrnAxonAddr_i,
  input  logic                          rdEn_LrnInSpike_i,
  output logic                          Lrn_InSpike_o,
  output logic [15:0]                   dropCnt_o,
  output logic                          busy_o
);

  localparam int ENTRY_W = CORE_ID_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
  localparam logic [FIFO_PTR_BIT_WIDTH:0] FULL_CNT = (FIFO_PTR_BIT_WIDTH+1)'(FIFO_DEPTH);

  // Only the destination core and axon index are kept; the rest of the packet is ignored.
  logic [ENTRY_W-1:0]            mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_BIT_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR_BIT_WIDTH:0]   count_q, count_d;
  logic [NUM_AXONS-1:0]          pending_q, pending_d, active_q, active_d;
  logic [15:0]                   drop_q, drop_d;
  logic                          rcl_q, rcl_d, lrn_q, lrn_d;

  logic                          push, pop, hit;
  logic [ENTRY_W-1:0]            pkt_entry, head;
  logic [CORE_ID_BIT_WIDTH-1:0]  head_core;
  logic [AXON_CNT_BIT_WIDTH-1:0] head_axon;
  logic [NUM_AXONS-1:0]          pop_onehot;
  logic                          unused_pkt_bits;

  assign unused_pkt_bits = ^pkt_i[AER_BIT_WIDTH-CORE_ID_BIT_WIDTH-1:AXON_CNT_BIT_WIDTH];
  assign pkt_entry  = {pkt_i[AER_BIT_WIDTH-1 -: CORE_ID_BIT_WIDTH], pkt_i[AXON_CNT_BIT_WIDTH-1:0]};

  assign pktReady_o = (count_q != FULL_CNT);
  assign busy_o     = (count_q != '0);
  assign push       = pktValid_i && pktReady_o;
  assign pop        = busy_o;
  assign head       = mem_q[rd_ptr_q];
  assign head_core  = head[ENTRY_W-1 -: CORE_ID_BIT_WIDTH];
  assign head_axon  = head[AXON_CNT_BIT_WIDTH-1:0];
  assign hit        = (head_core == CORE_ID) && (32'(head_axon) < 32'(NUM_AXONS));

  assign dropCnt_o     = drop_q;
  assign Rcl_InSpike_o = rcl_q;
  assign Lrn_InSpike_o = lrn_q;

  always_comb begin
    pop_onehot = '0;
    if (pop && hit) pop_onehot[head_axon] = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    drop_d = drop_q;
    if (pop && !hit && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    // A pop coinciding with start_i belongs to the new step.
    pending_d = start_i ? pop_onehot : (pending_q | pop_onehot);
    active_d  = start_i ? pending_q : active_q;

    rcl_d = rdEn_RclInSpike_i ? active_q[RclAxonAddr_i] : rcl_q;
    lrn_d = rdEn_LrnInSpike_i ? active_q[LrnAxonAddr_i] : lrn_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      active_q  <= '0;
      drop_q    <= '0;
      rcl_q     <= 1'b0;
      lrn_q     <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= pkt_entry;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      drop_q    <= drop_d;
      rcl_q     <= rcl_d;
      lrn_q     <= lrn_d;
    end
  end

endmodule

// File: tb/tb_spike_rx_buf.sv
// Directed bench for spike_rx_buf: reset, delivery, drops/saturation, streaming,
// step boundary and asynchronous reset, all with hand-computed expectations.
module tb_spike_rx_buf;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pkt_i = '0;
  logic        pktValid_i = 1'b0;
  logic        pktReady_o;
  logic [1:0]  RclAxonAddr_i = '0;
  logic        rdEn_RclInSpike_i = 1'b0;
  logic        Rcl_InSpike_o;
  logic [1:0]  LrnAxonAddr_i = '0;
  logic        rdEn_LrnInSpike_i = 1'b0;
  logic        Lrn_InSpike_o;
  logic [15:0] dropCnt_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  spike_rx_buf dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .pkt_i(pkt_i), .pktValid_i(pktValid_i), .pktReady_o(pktReady_o),
    .RclAxonAddr_i(RclAxonAddr_i), .rdEn_RclInSpike_i(rdEn_RclInSpike_i),
    .Rcl_InSpike_o(Rcl_InSpike_o),
    .LrnAxonAddr_i(LrnAxonAddr_i), .rdEn_LrnInSpike_i(rdEn_LrnInSpike_i),
    .Lrn_InSpike_o(Lrn_InSpike_o),
    .dropCnt_o(dropCnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] p);
    pkt_i = p;
    pktValid_i = 1'b1;
    step();
    pktValid_i = 1'b0;
  endtask

  // Reads every axon of the active vector through the recall port.
  task automatic rd_vec(output logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      RclAxonAddr_i = 2'(i);
      rdEn_RclInSpike_i = 1'b1;
      step();
      v[i] = Rcl_InSpike_o;
    end
    rdEn_RclInSpike_i = 1'b0;
  endtask

  logic [3:0] v;
  logic [31:0] stream_pkts [6];

  initial begin
    stream_pkts = '{32'h0100_0000, 32'h0100_0001, 32'h0100_0002,
                    32'h0100_0003, 32'h0100_0000, 32'h0100_0001};

    // Reset state
    #2;
    chk("rst_ready", 32'(pktReady_o), 32'd1);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_drop",  32'(dropCnt_o), 32'd0);
    chk("rst_rcl",   32'(Rcl_InSpike_o), 32'd0);
    chk("rst_lrn",   32'(Lrn_InSpike_o), 32'd0);
    #21 rst_n_i = 1'b1;
    step();
    pulse_start();
    rd_vec(v);
    chk("rst_active", 32'(v), 32'h0);

    // Basic delivery
    send(32'h0100_0002);
    chk("basic_busy", 32'(busy_o), 32'd1);
    step();
    chk("basic_drained", 32'(busy_o), 32'd0);
    pulse_start();
    RclAxonAddr_i = 2'd2; rdEn_RclInSpike_i = 1'b1;
    LrnAxonAddr_i = 2'd2; rdEn_LrnInSpike_i = 1'b1;
    step();
    chk("basic_rcl2", 32'(Rcl_InSpike_o), 32'd1);
    chk("basic_lrn2", 32'(Lrn_InSpike_o), 32'd1);
    RclAxonAddr_i = 2'd1; rdEn_LrnInSpike_i = 1'b0; LrnAxonAddr_i = 2'd0;
    step();
    chk("basic_rcl1", 32'(Rcl_InSpike_o), 32'd0);
    chk("basic_lrn_hold", 32'(Lrn_InSpike_o), 32'd1);
    rdEn_RclInSpike_i = 1'b0;

    // Upper packet bits outside core/axon fields are ignored
    send(32'h01FF_FFFD);
    step();
    pulse_start();
    rd_vec(v);
    chk("ignore_bits", 32'(v), 32'h2);

    // Drop counting
    send(32'h0200_0001);
    step();
    chk("drop_one", 32'(dropCnt_o), 32'd1);
    pulse_start();
    rd_vec(v);
    chk("drop_pending", 32'(v), 32'h0);

    // Saturation: stream enough wrong-core packets to reach 16'hFFFF
    pkt_i = 32'h0200_0001;
    pktValid_i = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    pktValid_i = 1'b0;
    step();
    chk("drop_ffff", 32'(dropCnt_o), 32'h0000_FFFF);
    send(32'h0300_0000);
    step();
    chk("drop_sat", 32'(dropCnt_o), 32'h0000_FFFF);

    // Back-to-back stream: no loss, ready stays high because each entry drains next cycle
    pulse_start();
    pktValid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pkt_i = stream_pkts[i];
      #1;
      chk($sformatf("stream_ready%0d", i), 32'(pktReady_o), 32'd1);
      step();
    end
    pktValid_i = 1'b0;
    chk("stream_busy", 32'(busy_o), 32'd1);
    step();
    chk("stream_drained", 32'(busy_o), 32'd0);
    chk("stream_nodrop", 32'(dropCnt_o), 32'h0000_FFFF);
    pulse_start();
    rd_vec(v);
    chk("stream_active", 32'(v), 32'hF);

    // Step boundary: pop of axon 3 coincides with start_i
    pulse_start();
    send(32'h0100_0000);
    step();
    send(32'h0100_0003);
    pulse_start();
    rd_vec(v);
    chk("boundary_active", 32'(v), 32'h1);
    pulse_start();
    rd_vec(v);
    chk("boundary_next", 32'(v), 32'h8);

    // Read on the start_i edge sees the pre-update active vector
    RclAxonAddr_i = 2'd3; rdEn_RclInSpike_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("read_old_active", 32'(Rcl_InSpike_o), 32'd1);
    step();
    chk("read_new_active", 32'(Rcl_InSpike_o), 32'd0);
    rdEn_RclInSpike_i = 1'b0;

    // Asynchronous reset mid-burst
    send(32'h0100_0002);
    step();
    pulse_start();
    RclAxonAddr_i = 2'd2; rdEn_RclInSpike_i = 1'b1;
    LrnAxonAddr_i = 2'd2; rdEn_LrnInSpike_i = 1'b1;
    step();
    rdEn_RclInSpike_i = 1'b0; rdEn_LrnInSpike_i = 1'b0;
    chk("pre_rst_rcl", 32'(Rcl_InSpike_o), 32'd1);
    pktValid_i = 1'b1;
    pkt_i = 32'h0100_0001;
    step();
    pkt_i = 32'h0100_0003;
    step();
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_busy",  32'(busy_o), 32'd0);
    chk("arst_ready", 32'(pktReady_o), 32'd1);
    chk("arst_drop",  32'(dropCnt_o), 32'd0);
    chk("arst_rcl",   32'(Rcl_InSpike_o), 32'd0);
    chk("arst_lrn",   32'(Lrn_InSpike_o), 32'd0);
    pktValid_i = 1'b0;
    #14 rst_n_i = 1'b1;
    step();
    chk("arst_idle", 32'(busy_o), 32'd0);
    pulse_start();
    rd_vec(v);
    chk("arst_lost", 32'(v), 32'h0);
    pulse_start();
    rd_vec(v);
    chk("arst_lost2", 32'(v), 32'h0);
    chk("arst_drop_after", 32'(dropCnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
